// File: rtl/cascade_mode_if.sv
// Cascade-bus signal bundle for the 8259A-compatible PIC.
// master: INTA sequencer / bus side; slave: cascade controller.
interface cascade_mode_if;
    logic [2:0] CAS;
    logic       SP;
    logic [2:0] ID;
    logic       flag_compare_at_slave;
    logic       flag_ID_match;
    logic       SP_output;
    logic [2:0] CAS_out;
    logic       CAS_oe;

    modport master (
        output CAS,
        output SP,
        output ID,
        output flag_compare_at_slave,
        input  flag_ID_match,
        input  SP_output,
        input  CAS_out,
        input  CAS_oe
    );

    modport slave (
        input  CAS,
        input  SP,
        input  ID,
        input  flag_compare_at_slave,
        output flag_ID_match,
        output SP_output,
        output CAS_out,
        output CAS_oe
    );
endinterface

// File: rtl/cascade_mode.sv
// Cascade-bus controller: master drives its ID onto CAS,
// slave flags a CAS/ID match while the compare strobe is high.
module cascade_mode #(
    parameter logic SLAVE  = 1'b0,
    parameter logic MASTER = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    cascade_mode_if.slave bus
);

    logic       match_q, match_d;
    logic       sp_q, sp_d;
    logic [2:0] cas_q, cas_d;
    logic       oe_q, oe_d;

    // Next-state: every output derives from the same role sample,
    // so a role switch lands on all outputs at one edge.
    always_comb begin
        match_d = 1'b0;
        sp_d    = 1'b0;
        cas_d   = 3'b000;
        oe_d    = 1'b0;
        case (bus.SP)
            MASTER: begin
                sp_d  = 1'b1;
                cas_d = bus.ID;
                oe_d  = 1'b1;
            end
            SLAVE: begin
                match_d = bus.flag_compare_at_slave
                        && (bus.CAS == bus.ID);
            end
            default: begin
                match_d = 1'b0;
            end
        endcase
    end

    // Output registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
            sp_q    <= 1'b0;
            cas_q   <= 3'b000;
            oe_q    <= 1'b0;
        end else begin
            match_q <= match_d;
            sp_q    <= sp_d;
            cas_q   <= cas_d;
            oe_q    <= oe_d;
        end
    end

    assign bus.flag_ID_match = match_q;
    assign bus.SP_output     = sp_q;
    assign bus.CAS_out       = cas_q;
    assign bus.CAS_oe        = oe_q;

endmodule

// File: tb/tb_cascade_mode.sv
// Scoreboard bench for cascade_mode: directed vectors push
// expected outputs, a monitor pops and compares after each edge.
module tb_cascade_mode;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cascade_mode_if bus();

    cascade_mode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // expected packing: {flag_ID_match, SP_output, CAS_out, CAS_oe}
    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    typedef struct {
        string      name;
        logic       sp;
        logic [2:0] id;
        logic [2:0] cas;
        logic       flag;
        logic [5:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[$];

    function automatic logic [5:0] dut_out();
        return {bus.flag_ID_match, bus.SP_output,
                bus.CAS_out, bus.CAS_oe};
    endfunction

    task automatic check_now(input string name,
                             input logic [5:0] exp);
        logic [5:0] act;
        act = dut_out();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t e;
        @(negedge clk);
        bus.SP = v.sp;
        bus.ID = v.id;
        bus.CAS = v.cas;
        bus.flag_compare_at_slave = v.flag;
        e.name = v.name;
        e.exp = v.exp;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic add(input string n, input logic sp,
                       input logic [2:0] id, input logic [2:0] cas,
                       input logic flag, input logic [5:0] exp);
        vec_t v;
        v.name = n;
        v.sp = sp;
        v.id = id;
        v.cas = cas;
        v.flag = flag;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Monitor: outputs are registered, so each edge retires one entry.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check_now(e.name, e.exp);
            end
        end
    end

    initial begin
        vec_t v;
        bus.SP = 1'b0;
        bus.ID = 3'b000;
        bus.CAS = 3'b000;
        bus.flag_compare_at_slave = 1'b0;

        //   name            sp  id      cas     flg  {m,sp,cas,oe}
        add("slave_match",   0, 3'b101, 3'b101, 1, 6'b1_0_000_0);
        add("slave_mismatch",0, 3'b010, 3'b101, 1, 6'b0_0_000_0);
        add("gate_off",      0, 3'b011, 3'b011, 0, 6'b0_0_000_0);
        add("gate_on",       0, 3'b011, 3'b011, 1, 6'b1_0_000_0);
        add("gate_drop",     0, 3'b011, 3'b011, 0, 6'b0_0_000_0);
        add("master",        1, 3'b110, 3'b110, 0, 6'b0_1_110_1);
        add("master_flag",   1, 3'b110, 3'b110, 1, 6'b0_1_110_1);
        add("role_switch",   0, 3'b110, 3'b110, 1, 6'b1_0_000_0);
        add("master_id001",  1, 3'b001, 3'b111, 1, 6'b0_1_001_1);
        add("slave_partial", 0, 3'b100, 3'b101, 1, 6'b0_0_000_0);
        add("slave_zero",    0, 3'b000, 3'b000, 1, 6'b1_0_000_0);
        add("slave_seven",   0, 3'b111, 3'b111, 1, 6'b1_0_000_0);
        add("cas_change",    0, 3'b111, 3'b110, 1, 6'b0_0_000_0);
        add("back_master",   1, 3'b110, 3'b000, 0, 6'b0_1_110_1);

        #2 reset = 1'b1;
        #1 check_now("reset_state", 6'b0_0_000_0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-run reset while in master role must clear at once.
        #3 reset = 1'b1;
        #1 check_now("async_reset", 6'b0_0_000_0);
        @(posedge clk);
        #1 check_now("reset_hold", 6'b0_0_000_0);
        @(negedge clk);
        reset = 1'b0;
        #1 check_now("reset_release", 6'b0_0_000_0);

        v.name = "post_reset";
        v.sp = 1'b1;
        v.id = 3'b011;
        v.cas = 3'b000;
        v.flag = 1'b0;
        v.exp = 6'b0_1_011_1;
        apply(v);

        for (int k = 0; k < 5 && sbq.size() != 0; k++)
            @(negedge clk);
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d pending expected 0",
                     sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
